// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read side: output-stage state encodings
// and Gray/binary conversion helpers (operate on FN_W bits; callers cast to width).
package fifo_pkg;

    localparam int FN_W = 32;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL   = 2'd1,
        STREAM = 2'd2
    } out_state_t;

    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
        logic [FN_W-1:0] b;
        b[FN_W-1] = g[FN_W-1];
        for (int i = FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter of parameterised width.
// Only instantiated when FIFO_RD_LEVEL_EN is defined.
module fifo_gray2bin
    import fifo_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    assign bin = WIDTH'(gray2bin(FN_W'(gray)));

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of an async FIFO with a registered output stage.
// Optional occupancy output rlevel is enabled by defining FIFO_RD_LEVEL_EN.
//
//   state  | meaning
//   EMPTY  | output register holds no word (rvalid=0)
//   FULL   | output register holds a word, waiting for rready
//   STREAM | as FULL, entered on back-to-back transfers (kept for coverage)
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 5
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic [ADDR_SIZE:0]   rq2_wptr,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic [ADDR_SIZE:0]   rptr,
    output logic                 rempty,
    output logic [DATA_SIZE-1:0] rdout,
    output logic                 rvalid,
    input  logic                 rready
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [ADDR_SIZE+1:0] rlevel
`endif
);

    typedef logic [ADDR_SIZE:0] ptr_t;

    out_state_t state, state_next;
    ptr_t       rbin, rbin_next, rgray_next;
    logic       pop;

    // rvalid is decoded from the registered state, so it stays a flop output.
    assign rvalid     = (state != EMPTY);
    assign pop        = !rempty && (!rvalid || rready);
    assign rbin_next  = rbin + ptr_t'(pop);
    assign rgray_next = ptr_t'(bin2gray(FN_W'(rbin_next)));
    assign raddr      = rbin[ADDR_SIZE-1:0];

    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: begin
                if (pop) state_next = FULL;
            end
            FULL, STREAM: begin
                if (rready) state_next = pop ? STREAM : EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state  <= EMPTY;
            rbin   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
            rdout  <= '0;
        end else begin
            state  <= state_next;
            rbin   <= rbin_next;
            rptr   <= rgray_next;
            rempty <= (rgray_next == rq2_wptr);
            if (pop) rdout <= mem_rdata;
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    ptr_t                 wbin;
    logic [ADDR_SIZE+1:0] level_next;

    fifo_gray2bin #(.WIDTH(ADDR_SIZE + 1)) u_wptr_g2b (
        .gray (rq2_wptr),
        .bin  (wbin)
    );

    // Words still in memory plus the one held in the output register.
    assign level_next = {1'b0, ptr_t'(wbin - rbin_next)}
                      + (ADDR_SIZE+2)'(state_next != EMPTY);

    always_ff @(posedge rclk) begin
        if (rrst) rlevel <= '0;
        else      rlevel <= level_next;
    end
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Scoreboard bench for fifo_read_ctrl: a write-side model feeds memory and a
// queue of expected words; a negedge monitor checks every accepted word.
module tb_fifo_read_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          rclk = 1'b0;
    logic          rrst = 1'b1;
    logic [AW:0]   rq2_wptr = '0;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          rempty;
    logic [DW-1:0] rdout;
    logic          rvalid;
    logic          rready = 1'b0;
`ifdef FIFO_RD_LEVEL_EN
    logic [AW+1:0] rlevel;
`endif

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [AW:0]   wbin = '0;
    logic [AW:0]   prev_rptr = '0;
    logic [AW-1:0] prev_raddr = '0;
    logic          gray_chk = 1'b0;
    int            n_cmp = 0;
    int            n_err = 0;
    int            n_rx = 0;
    int            wraps = 0;
    int            rx0;
    int            w0;

    assign mem_rdata = mem[raddr];

    fifo_read_ctrl #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rq2_wptr  (rq2_wptr),
        .mem_rdata (mem_rdata),
        .raddr     (raddr),
        .rptr      (rptr),
        .rempty    (rempty),
        .rdout     (rdout),
        .rvalid    (rvalid),
        .rready    (rready)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .rlevel    (rlevel)
`endif
    );

    always #5 rclk = ~rclk;

    function automatic logic [AW:0] to_gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] from_gray(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        mem[wbin[AW-1:0]] = d;
        exp_q.push_back(d);
        wbin     = wbin + 1'b1;
        rq2_wptr = to_gray(wbin);
    endtask

    task automatic reset_all();
        rrst     = 1'b1;
        rready   = 1'b0;
        wbin     = '0;
        rq2_wptr = '0;
        tick();
        tick();
        exp_q.delete();
        rrst = 1'b0;
    endtask

    // Monitor: every handshake seen before the edge must match the queue head.
    always @(negedge rclk) begin
        if (!rrst && rvalid && rready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got 0x%0h expected none", rdout);
            end else begin
                check("rdout_order", rdout, exp_q.pop_front());
                n_rx <= n_rx + 1;
            end
        end
        if (gray_chk && rptr != prev_rptr)
            check("rptr_gray_step", rptr, to_gray(from_gray(prev_rptr) + 1'b1));
        if (prev_raddr == 5'd31 && raddr == 5'd0) wraps <= wraps + 1;
        prev_rptr  <= rptr;
        prev_raddr <= raddr;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // reset
        reset_all();
        check("rst_rempty", rempty, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_rptr", rptr, 0);
        check("rst_rdout", rdout, 0);
        check("rst_raddr", raddr, 0);

        // rready with nothing stored is ignored
        rready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("idle_rvalid", rvalid, 0);
        check("idle_rptr", rptr, 0);
        check("idle_rempty", rempty, 1);
        rready = 1'b0;

        // first word latency
        rx0 = n_rx;
        write_word(32'hA5A5_A5A5);
        tick();
        check("first_rempty_p1", rempty, 0);
        check("first_rvalid_p1", rvalid, 0);
        tick();
        check("first_rvalid_p2", rvalid, 1);
        check("first_rdout_p2", rdout, 32'hA5A5_A5A5);
        check("first_rptr", rptr, 1);
        check("first_raddr", raddr, 1);
        rready = 1'b1;
        tick();
        check("first_rvalid_after", rvalid, 0);
        check("first_rx", n_rx - rx0, 1);
        rready = 1'b0;

        // backpressure
        reset_all();
        write_word(32'hB000_0000);
        tick();
        write_word(32'hB000_0001);
        tick();
        write_word(32'hB000_0002);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_rdout_stable", rdout, 32'hB000_0000);
            check("bp_rvalid_held", rvalid, 1);
        end
        check("bp_rptr", rptr, 1);
        check("bp_rempty", rempty, 0);
        rx0 = n_rx;
        rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_rvalid_stream", rvalid, (i < 2) ? 1 : 0);
        end
        check("bp_rx", n_rx - rx0, 3);
        check("bp_queue_empty", exp_q.size(), 0);
        rready = 1'b0;

        // wrap: 70 words streamed through a 32-deep memory
        reset_all();
        rx0 = n_rx;
        w0 = wraps;
        gray_chk = 1'b1;
        rready = 1'b1;
        for (int i = 0; i < 70; i++) begin
            write_word(32'h1000_0000 + 32'(i));
            tick();
        end
        begin
            int k = 0;
            while ((exp_q.size() != 0 || rvalid) && k < 20) begin
                tick();
                k++;
            end
        end
        tick();
        check("wrap_drain_done", exp_q.size(), 0);
        check("wrap_rx", n_rx - rx0, 70);
        check("wrap_raddr_wraps", wraps - w0, 2);
        check("wrap_rptr_final", rptr, 6'd5);
        check("wrap_rempty", rempty, 1);
        check("wrap_rvalid", rvalid, 0);
        gray_chk = 1'b0;
        rready = 1'b0;

        // reset while a word is being handed over
        reset_all();
        rready = 1'b1;
        write_word(32'hC000_0000);
        tick();
        write_word(32'hC000_0001);
        tick();
        check("midrst_pre_rvalid", rvalid, 1);
        rx0 = n_rx;
        rrst     = 1'b1;
        wbin     = '0;
        rq2_wptr = '0;
        tick();
        exp_q.delete();
        check("midrst_rvalid", rvalid, 0);
        check("midrst_rptr", rptr, 0);
        check("midrst_rempty", rempty, 1);
        check("midrst_rdout", rdout, 0);
        rrst = 1'b0;
        tick();
        tick();
        check("midrst_no_pop_rvalid", rvalid, 0);
        check("midrst_no_pop_rptr", rptr, 0);
        check("midrst_rx", n_rx - rx0, 0);
        rready = 1'b0;

`ifdef FIFO_RD_LEVEL_EN
        // occupancy
        reset_all();
        check("lvl_rst", rlevel, 0);
        for (int i = 0; i < 32; i++) begin
            write_word(32'h2000_0000 + 32'(i));
            tick();
        end
        tick();
        tick();
        check("lvl_full_popped", rlevel, 32);
        check("lvl_full_rvalid", rvalid, 1);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("lvl_after_accept", rlevel, 31);
        write_word(32'h2000_0020);
        tick();
        write_word(32'h2000_0021);
        tick();
        check("lvl_max", rlevel, 33);
        rready = 1'b1;
        begin
            int k = 0;
            while ((exp_q.size() != 0 || rvalid) && k < 50) begin
                tick();
                k++;
            end
        end
        tick();
        check("lvl_drain_done", exp_q.size(), 0);
        check("lvl_drained", rlevel, 0);
        rready = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_read_ctrl.md
FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, the FIFO word width.
REQ-002 SHALL have parameter ADDR_SIZE, default 5, the memory address width; DEPTH = 2^ADDR_SIZE.
REQ-003 SHALL have port rclk, input, 1, the single read-domain clock; all logic is on its rising edge.
REQ-004 SHALL have port rrst, input, 1, the reset; it is synchronous and active-high.
REQ-005 SHALL have port rq2_wptr, input, ADDR_SIZE+1, the Gray write pointer, already synchronized into rclk.
REQ-006 SHALL have port mem_rdata, input, DATA_SIZE, the combinational memory read data at raddr.
REQ-007 SHALL have port raddr, output, ADDR_SIZE, the memory read address.
REQ-008 SHALL have port rptr, output, ADDR_SIZE+1, the registered Gray read pointer, for the write-side synchronizer.
REQ-009 SHALL have port rempty, output, 1, the registered memory-empty flag.
REQ-010 SHALL have port rdout, output, DATA_SIZE, the output data register.
REQ-011 SHALL have port rvalid, output, 1, which marks rdout as valid.
REQ-012 SHALL have port rready, input, 1, the consumer accept signal.
REQ-013 SHALL have port rlevel, output, ADDR_SIZE+2, the occupancy; this port is present only with FIFO_RD_LEVEL_EN.

Function
REQ-014 SHALL hold the binary read pointer rbin (ADDR_SIZE+1 bits), with raddr = rbin[ADDR_SIZE-1:0].
REQ-015 SHALL present rptr as the Gray code of rbin: (rbin>>1)^rbin, registered, wrapping modulo 2^(ADDR_SIZE+1).
REQ-016 SHALL define pop = !rempty && (!rvalid || rready).
REQ-017 SHALL, on pop, load rdout <= mem_rdata, set rvalid <= 1, and increment rbin and rptr in the same edge.
REQ-018 SHALL, when rvalid && rready && !pop, clear rvalid and hold rdout.
REQ-019 SHALL, when rvalid && !rready, hold rdout, rvalid, rbin and rptr unchanged (no data loss, no reorder).
REQ-020 SHALL register rempty <= (Gray of next rbin == rq2_wptr), where next rbin = rbin + pop.
REQ-021 SHALL operate as an output state machine with these states and transitions:
- EMPTY (rvalid=0) goes to FULL on pop.
- FULL (rvalid=1, stalled) goes to STREAM when rready && pop.
- FULL goes to EMPTY when rready && rempty.
- STREAM behaves as FULL and is kept distinct only for coverage.
REQ-022 SHALL have latency from rq2_wptr becoming non-equal to rptr: rempty falls at +1 edge and rvalid rises at +2 edges.
REQ-023 SHALL sustain one word per clock while the memory is non-empty and rready is held high.
REQ-024 SHALL never pop when rempty=1; rready while rvalid=0 is ignored.
REQ-025 SHALL ensure rempty and rvalid are never both 0 while the memory holds data for more than 1 cycle.

Reset
REQ-026 SHALL, with rrst high at a clock edge, set rbin=0, rptr=0, rempty=1, rvalid=0, rdout=0, rlevel=0, state=EMPTY.
REQ-027 SHALL, when reset occurs mid-stream, discard the held word; the write side must be reset in the same cycle.

Configuration
REQ-028 SHALL, with macro FIFO_RD_LEVEL_EN defined, output rlevel = (gray2bin(rq2_wptr) - rbin) + rvalid, registered and ranging 0..DEPTH+1.
REQ-029 SHALL, without FIFO_RD_LEVEL_EN, omit the rlevel port and the gray-to-binary logic entirely.

Structure
REQ-030 SHALL place the output-state encodings (EMPTY/FULL/STREAM) and the bin2gray/gray2bin functions in shared package fifo_pkg.
REQ-031 SHALL instantiate one sub-module, fifo_gray2bin (parameter WIDTH), under FIFO_RD_LEVEL_EN only.

Verification
REQ-032 SHALL cover reset: assert rrst for 2 cycles -> rempty=1, rvalid=0, rptr=0, rdout=0.
REQ-033 SHALL cover first word: rq2_wptr 0->1 with mem_rdata=0xA5A5A5A5 -> rempty=0 at +1, rvalid=1 and rdout=0xA5A5A5A5 at +2, rptr=1.
REQ-034 SHALL cover backpressure: 3 words queued, rready=0 for 10 cycles -> rdout stable and rptr=1; then rready=1 -> 3 consecutive words, rvalid=0 after the last.
REQ-035 SHALL cover wrap: stream 70 words with ADDR_SIZE=5 -> raddr wraps 31->0 twice, rptr Gray sequence correct, data in order.
REQ-036 SHALL cover the level check (FIFO_RD_LEVEL_EN): 32 words written, none read -> rlevel=32; after 1 pop -> rlevel=32 (31+rvalid); after rready accepts -> 31.
REQ-037 SHALL cover reset mid-stream: rrst during rvalid=1 && rready=1 -> next cycle rvalid=0, no extra pop, rptr=0.
